// File: rtl/multicycle_ctrl_fsm_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
//   Bundles the signals between the multi-cycle control unit and the shared
//   datapath: IR fields, ALU flag and memory handshake in; mux selects,
//   strobes and status out.
//   master : the control unit (drives selects/strobes, reads IR/flags)
//   slave  : the datapath side (drives IR/flags, reads selects/strobes)
// Parameter CNT_W sets the width of the retired-instruction counter.
// ----------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    // Datapath -> control
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    // Control -> datapath
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_src;
    logic             pc_en;
    logic             illegal_op;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
               illegal_op, state_o, retired_cnt
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
               illegal_op, state_o, retired_cnt
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Multi-cycle MIPS control unit. Steps the shared datapath through
//   fetch/decode/execute/write-back, driving mux selects and PC/IR/regfile/
//   memory strobes, stalling in FETCH/MEMRD/MEMWR until mem_ready.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; all outputs forced to 0 while high
//   bus  : multicycle_ctrl_fsm_if.master (IR fields, zero, mem_ready in;
//          selects, strobes, illegal_op, state_o, retired_cnt out)
// ----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_ctrl_fsm_if.master  bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire_s;
    logic             unused_funct_s;

    // funct is decoded by the ALU control, not here
    assign unused_funct_s = ^bus.funct;

    // State and retired-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state decode; unused codes 12-15 recover to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Retire on the last cycle of each legal instruction (sw only once memory accepts)
    always_comb begin
        retire_s = 1'b0;
        case (state_q)
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: retire_s = 1'b1;
            S_MEMWR: retire_s = bus.mem_ready;
            default: retire_s = 1'b0;
        endcase
        if (retire_s) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
    end

    // Datapath controls from current state; everything held at 0 during reset
    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.iord        = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.alu_op      = 2'b00;
        bus.pc_src      = 2'b00;
        bus.pc_en       = 1'b0;
        bus.illegal_op  = 1'b0;
        bus.state_o     = state_q;
        bus.retired_cnt = retired_q;
        if (rst) begin
            bus.state_o     = 4'd0;
            bus.retired_cnt = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_en     = bus.mem_ready;
                end
                S_DECODE: begin
                    // branch target precomputed into ALUOut
                    bus.alu_src_b = 2'b11;
                    case (bus.opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI:
                                 bus.illegal_op = 1'b0;
                        default: bus.illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR, S_ADDIEX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                end
                S_MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                end
                S_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b01;
                    bus.pc_src    = 2'b01;
                    bus.pc_en     = bus.zero;
                end
                S_JUMP: begin
                    bus.pc_src = 2'b10;
                    bus.pc_en  = 1'b1;
                end
                S_ADDIWB: begin
                    bus.reg_write = 1'b1;
                end
                default: begin
                    bus.mem_read = 1'b0;
                end
            endcase
        end
    end

endmodule
